traffic_phase_ctrl: RTL

Parametrised N-phase traffic-signal sequencer for an intersection controller. It generalises the fixed 4-way green/yellow cycle to NUM_PHASES phases with programmable green, yellow and all-red clearance durations. It supports demand-driven phase skipping and a hold input. Per-phase light outputs use the codebase encoding: 3'b001 green, 3'b010 yellow, 3'b100 red.

---
 rtl/traffic_phase_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase traffic sequencer (GREEN -> YELLOW -> ALL_RED -> next GREEN).
// Latency: state/cur_phase registered; lights decoded combinationally from them.
// Backpressure: hold freezes everything; optional preemption via TRAFFIC_PREEMPT_EN.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 8,
  localparam int PH_W      = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst_a,
  input  logic                    hold,
  input  logic [NUM_PHASES-1:0]   phase_req,
  input  logic                    preempt_req,
  input  logic [PH_W-1:0]         preempt_phase,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PH_W-1:0]         cur_phase,
  output logic [1:0]              state,
  output logic                    preempt_active
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_ALLRED = 2'b10
  } st_t;

  st_t              st;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] dur_last;
  logic [PH_W-1:0]  nxt_phase;
  logic             pre_vld;

`ifdef TRAFFIC_PREEMPT_EN
  // A preemption target outside the phase range is treated as no request.
  assign pre_vld = preempt_req && (int'(preempt_phase) < NUM_PHASES);
`else
  logic unused_preempt;
  assign unused_preempt = preempt_req ^ (^preempt_phase);
  assign pre_vld        = 1'b0;
`endif

  assign state = st;

  // Last count value of the current state's dwell.
  always_comb begin
    dur_last = CNT_W'(GREEN_CYC - 1);
    case (st)
      S_YELLOW: dur_last = CNT_W'(YELLOW_CYC - 1);
      S_ALLRED: dur_last = CNT_W'(ALLRED_CYC - 1);
      default:  dur_last = CNT_W'(GREEN_CYC - 1);
    endcase
  end

  // Cyclic demand scan starting after cur_phase; falls back to plain rotation.
  always_comb begin
    int   cand;
    logic found;
    found = 1'b0;
    cand  = 0;
    nxt_phase = (cur_phase == PH_W'(NUM_PHASES - 1)) ? '0 : cur_phase + PH_W'(1);
    for (int i = 1; i <= NUM_PHASES; i++) begin
      cand = int'(cur_phase) + i;
      if (cand >= NUM_PHASES) cand = cand - NUM_PHASES;
      if (!found && phase_req[cand]) begin
        nxt_phase = PH_W'(cand);
        found     = 1'b1;
      end
    end
  end

  // Sequencer: dwell counting, transitions, preemption; hold overrides all.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      st             <= S_GREEN;
      cur_phase      <= '0;
      count          <= '0;
      preempt_active <= 1'b0;
    end else if (!hold) begin
      case (st)
        S_GREEN: begin
          if (pre_vld && (cur_phase != preempt_phase)) begin
            st             <= S_YELLOW;
            count          <= '0;
            preempt_active <= 1'b0;
          end else if (pre_vld) begin
            // Serving the preemption target: keep green indefinitely.
            count          <= '0;
            preempt_active <= 1'b1;
          end else begin
            preempt_active <= 1'b0;
            if (count == dur_last) begin
              st    <= S_YELLOW;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        S_YELLOW: begin
          preempt_active <= 1'b0;
          if (count == dur_last) begin
            st    <= S_ALLRED;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          if (count == dur_last) begin
            st             <= S_GREEN;
            count          <= '0;
            cur_phase      <= pre_vld ? preempt_phase : nxt_phase;
            preempt_active <= pre_vld;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Light decode: only cur_phase may be non-red, and only in GREEN/YELLOW.
  always_comb begin
    lights = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      lights[3*p +: 3] = 3'b100;
      if (cur_phase == PH_W'(p)) begin
        if (st == S_GREEN)  lights[3*p +: 3] = 3'b001;
        if (st == S_YELLOW) lights[3*p +: 3] = 3'b010;
      end
    end
  end

endmodule
